// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding unit.
//   hz_state_e   : externally visible controller state encoding
//   shd_flags_t  : flag fields of one shadow-pipeline entry. The full entry
//                  is {shd_flags_t, rfWeSel} with the flags in the MSBs.
//   FWD_NONE     : forward select meaning "use the register file value"
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FROZEN  = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic valid;
    logic regw;
    logic memrd;
  } shd_flags_t;

  localparam int unsigned SHD_FLAG_W = $bits(shd_flags_t);

  localparam int unsigned FWD_NONE = 0;

  function automatic int unsigned shd_entry_w(input int unsigned aw);
    return aw + SHD_FLAG_W;
  endfunction

endpackage

// File: rtl/hazard_match_prio.sv
// Priority matcher for one source operand against the shadow pipeline.
//   src_use  : operand is actually read
//   src_sel  : operand register address
//   shd_vec  : shadow entries, entry k (1-based) at bits [(k-1)*EW +: EW]
//   hit      : some in-flight writer matches
//   stage    : stage index k of the youngest matching writer (0 if none)
//   is_load  : that winning writer is a load
module hazard_match_prio
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned FSW        = 2
) (
  input  logic                                         src_use,
  input  logic [REG_AW-1:0]                            src_sel,
  input  logic [FWD_STAGES*(REG_AW+SHD_FLAG_W)-1:0]    shd_vec,
  output logic                                         hit,
  output logic [FSW-1:0]                               stage,
  output logic                                         is_load
);

  localparam int unsigned EW = REG_AW + SHD_FLAG_W;

  logic [EW-1:0]     entry;
  shd_flags_t        flags;
  logic [REG_AW-1:0] wsel;

  always_comb begin
    hit     = 1'b0;
    stage   = '0;
    is_load = 1'b0;
    entry   = '0;
    flags   = '0;
    wsel    = '0;
    // Scan youngest first; the first hit is kept so younger writers win.
    for (int unsigned k = 0; k < FWD_STAGES; k++) begin
      entry = shd_vec[k*EW +: EW];
      flags = shd_flags_t'(entry[EW-1 -: SHD_FLAG_W]);
      wsel  = entry[REG_AW-1:0];
      if (!hit && src_use && flags.valid && flags.regw &&
          (wsel != '0) && (wsel == src_sel)) begin
        hit     = 1'b1;
        stage   = FSW'(k + 1);
        is_load = flags.memrd;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding unit for the in-order pipeline.
// Tracks in-flight destinations in a FWD_STAGES-deep shadow pipeline,
// produces EX-aligned forward selects, and stalls ID on load-use hazards.
//   Clk, Rst_n          : clock, async active-low reset
//   ID_valid            : ID holds a real instruction
//   ID_rfReSel/ReUse    : per-source register address / read enable
//   ID_RegW, ID_MemRd   : ID instruction writes RF / is a load
//   ID_rfWeSel          : ID destination register
//   Flush               : kill the ID instruction
//   Hold_ext            : external freeze, all state holds
//   Stall_ID, Bubble_EX : load-use stall of ID and NOP into ID/EX
//   Forward             : per-source select (0 = RF, k = shadow stage k)
//   State               : 0 RUN, 1 LDSTALL, 2 FROZEN
//   StallCnt            : saturating load-use stall cycle count
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter  int unsigned REG_AW     = 5,
  parameter  int unsigned NUM_SRC    = 2,
  parameter  int unsigned FWD_STAGES = 2,
  parameter  int unsigned LOAD_LAT   = 2,
  localparam int unsigned FSW        = $clog2(FWD_STAGES + 1)
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       ID_valid,
  input  logic [NUM_SRC*REG_AW-1:0]  ID_rfReSel,
  input  logic [NUM_SRC-1:0]         ID_rfReUse,
  input  logic                       ID_RegW,
  input  logic                       ID_MemRd,
  input  logic [REG_AW-1:0]          ID_rfWeSel,
  input  logic                       Flush,
  input  logic                       Hold_ext,
  output logic                       Stall_ID,
  output logic                       Bubble_EX,
  output logic [NUM_SRC*FSW-1:0]     Forward,
  output logic [1:0]                 State,
  output logic [15:0]                StallCnt
);

  localparam int unsigned EW = shd_entry_w(REG_AW);

  logic [FWD_STAGES*EW-1:0] shd_q, shd_d;
  logic [NUM_SRC*FSW-1:0]   fwd_q, fwd_d;
  logic [15:0]              cnt_q, cnt_d;
  hz_state_e                state_q, state_d;

  logic [NUM_SRC-1:0]       hit, is_load;
  logic [NUM_SRC*FSW-1:0]   stage_v;
  logic                     ld_use, hazard, stall, issue;
  shd_flags_t               new_flags;

  for (genvar gs = 0; gs < NUM_SRC; gs++) begin : g_src
    hazard_match_prio #(
      .REG_AW     (REG_AW),
      .FWD_STAGES (FWD_STAGES),
      .FSW        (FSW)
    ) u_match (
      .src_use (ID_rfReUse[gs]),
      .src_sel (ID_rfReSel[gs*REG_AW +: REG_AW]),
      .shd_vec (shd_q),
      .hit     (hit[gs]),
      .stage   (stage_v[gs*FSW +: FSW]),
      .is_load (is_load[gs])
    );
  end

  // A load is only a hazard if it is the youngest writer and its data is
  // not yet forwardable; Flush overrides so the killed instruction never stalls.
  always_comb begin
    ld_use = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (hit[s] && is_load[s] && (32'(stage_v[s*FSW +: FSW]) < LOAD_LAT)) begin
        ld_use = 1'b1;
      end
    end
    hazard = ld_use & ID_valid & ~Flush;
    stall  = hazard & ~Hold_ext;
    issue  = ID_valid & ~Flush & ~stall;
  end

  // Shadow shift, forward select capture and stall counter. Current shadow
  // stage k becomes stage k relative to the issuing instruction's EX cycle,
  // so the match index is captured unchanged.
  always_comb begin
    shd_d     = shd_q;
    fwd_d     = fwd_q;
    cnt_d     = cnt_q;
    new_flags = '0;
    if (!Hold_ext) begin
      for (int unsigned k = 1; k < FWD_STAGES; k++) begin
        shd_d[k*EW +: EW] = shd_q[(k-1)*EW +: EW];
      end
      new_flags.valid = issue;
      new_flags.regw  = issue & ID_RegW;
      new_flags.memrd = issue & ID_MemRd;
      shd_d[0 +: EW]  = {new_flags, (issue ? ID_rfWeSel : REG_AW'(0))};
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        fwd_d[s*FSW +: FSW] = (issue && hit[s]) ? stage_v[s*FSW +: FSW]
                                                : FSW'(FWD_NONE);
      end
      if (stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      shd_q <= '0;
      fwd_q <= '0;
      cnt_q <= '0;
    end else begin
      shd_q <= shd_d;
      fwd_q <= fwd_d;
      cnt_q <= cnt_d;
    end
  end

  // Controller state register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Controller next state
  always_comb begin
    state_d = state_q;
    if (Hold_ext) begin
      state_d = ST_FROZEN;
    end else begin
      unique case (state_q)
        ST_RUN:     if (hazard)  state_d = ST_LDSTALL;
        ST_LDSTALL: if (!hazard) state_d = ST_RUN;
        ST_FROZEN:  state_d = ST_RUN;
        default:    state_d = ST_RUN;
      endcase
    end
  end

  // Controller outputs
  always_comb begin
    State     = state_q;
    Stall_ID  = stall;
    Bubble_EX = stall;
    Forward   = fwd_q;
    StallCnt  = cnt_q;
  end

endmodule
